// File: rtl/conv_seq_ctrl.sv
// Command sequencer for a sliding-window convolution engine.
// For each time step and output pixel, it issues FILTER_LEN^2 MAC commands followed by one flush command.
module conv_seq_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int IFMAP_LEN  = 5,
  parameter int FILTER_LEN = 3,
  parameter int STRIDE     = 1,
  parameter int TIMESTEPS  = 1,
  localparam int TS_W      = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              abort,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_filter_addr,
  output logic [ADDR_W-1:0] cmd_ifmap_addr,
  output logic              cmd_acc_clear,
  output logic              cmd_flush,
  output logic [TS_W-1:0]   cmd_ts,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [1:0]        dbg_state
);

  localparam int OUT_LEN = (IFMAP_LEN - FILTER_LEN) / STRIDE + 1;
  localparam int CW      = $clog2(IFMAP_LEN + 1);
  localparam logic [ADDR_W-1:0] IL_A = ADDR_W'(IFMAP_LEN);
  localparam logic [ADDR_W-1:0] FL_A = ADDR_W'(FILTER_LEN);
  localparam logic [ADDR_W-1:0] ST_A = ADDR_W'(STRIDE);

  generate
    if (FILTER_LEN > IFMAP_LEN || STRIDE == 0 || TIMESTEPS == 0 ||
        (IFMAP_LEN * IFMAP_LEN - 1) >= (1 << ADDR_W)) begin : g_bad_params
      $error("conv_seq_ctrl: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TS_W-1:0] r_ts;
  logic [CW-1:0]   r_oy, r_ox, r_fy, r_fx;

  logic w_xfer, w_fx_last, w_fy_last, w_ox_last, w_oy_last, w_ts_last, w_run;

  // Handshakes: a beat moves only on an edge where valid && ready are both high.
  // valid never drops and the payload never changes while waiting for ready, except on abort or reset.
  assign w_run     = (r_state == S_MAC) || (r_state == S_FLUSH);
  assign w_xfer    = w_run && cmd_ready;
  assign w_fx_last = (r_fx == CW'(FILTER_LEN - 1));
  assign w_fy_last = (r_fy == CW'(FILTER_LEN - 1));
  assign w_ox_last = (r_ox == CW'(OUT_LEN - 1));
  assign w_oy_last = (r_oy == CW'(OUT_LEN - 1));
  assign w_ts_last = (r_ts == TS_W'(TIMESTEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ts    <= '0;
      r_oy    <= '0;
      r_ox    <= '0;
      r_fy    <= '0;
      r_fx    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_run || abort) begin
        r_ts <= '0;
        r_oy <= '0;
        r_ox <= '0;
        r_fy <= '0;
        r_fx <= '0;
      end else if (w_xfer && r_state == S_MAC) begin
        // fy/fx stay at their last value so the flush carries the final MAC addresses.
        if (!w_fx_last) begin
          r_fx <= r_fx + 1'b1;
        end else if (!w_fy_last) begin
          r_fx <= '0;
          r_fy <= r_fy + 1'b1;
        end
      end else if (w_xfer) begin
        r_fx <= '0;
        r_fy <= '0;
        if (!w_ox_last) begin
          r_ox <= r_ox + 1'b1;
        end else begin
          r_ox <= '0;
          if (!w_oy_last) begin
            r_oy <= r_oy + 1'b1;
          end else begin
            r_oy <= '0;
            r_ts <= w_ts_last ? '0 : r_ts + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_state_nxt = S_MAC;
      S_MAC: begin
        if (abort) w_state_nxt = S_IDLE;
        else if (w_xfer && w_fx_last && w_fy_last) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (abort) w_state_nxt = S_IDLE;
        else if (w_xfer) w_state_nxt = (w_ox_last && w_oy_last && w_ts_last) ? S_DONE : S_MAC;
      end
      S_DONE:  if (abort || done_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_ready     = (r_state == S_IDLE);
    cmd_valid       = w_run;
    cmd_flush       = (r_state == S_FLUSH);
    cmd_acc_clear   = (r_state == S_MAC) && (r_fy == '0) && (r_fx == '0);
    done_valid      = (r_state == S_DONE);
    cmd_ts          = '0;
    cmd_filter_addr = '0;
    cmd_ifmap_addr  = '0;
    if (w_run) begin
      cmd_ts          = r_ts;
      cmd_filter_addr = ADDR_W'(r_fy) * FL_A + ADDR_W'(r_fx);
      cmd_ifmap_addr  = (ADDR_W'(r_oy) * ST_A + ADDR_W'(r_fy)) * IL_A
                        + ADDR_W'(r_ox) * ST_A + ADDR_W'(r_fx);
    end
    dbg_state = r_state;
  end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: width of both address fields.
REQ-002 Parameter IFMAP_LEN, default 5: side length of the square ifmap.
REQ-003 Parameter FILTER_LEN, default 3: side length of the square filter.
REQ-004 Parameter STRIDE, default 1: window step in both dimensions.
REQ-005 Parameter TIMESTEPS, default 1: number of full passes per start (SNN time steps).
REQ-006 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-007 Port rst_n  in  1  reset, synchronous and active-low.
REQ-008 Port start_valid / start_ready  in / out  1 / 1  start handshake.
REQ-009 Port abort  in  1  synchronous abort of the current run.
REQ-010 Port cmd_valid / cmd_ready  out / in  1 / 1  command channel handshake.
REQ-011 Port cmd_filter_addr  out  ADDR_W  filter address fy*FILTER_LEN+fx.
REQ-012 Port cmd_ifmap_addr  out  ADDR_W  ifmap address (oy*STRIDE+fy)*IFMAP_LEN+(ox*STRIDE+fx).
REQ-013 Port cmd_acc_clear  out  1  accumulator clear, set on the first MAC of each output pixel.
REQ-014 Port cmd_flush  out  1  split/add select, set on the flush command.
REQ-015 Port cmd_ts  out  TS_W=max(1,$clog2(TIMESTEPS))  current time step.
REQ-016 Port done_valid / done_ready  out / in  1 / 1  completion handshake.

Function
REQ-017 OUT_LEN SHALL equal (IFMAP_LEN-FILTER_LEN)/STRIDE+1, using integer division.
REQ-018 Elaboration SHALL fail if FILTER_LEN>IFMAP_LEN, STRIDE==0, TIMESTEPS==0, or IFMAP_LEN^2-1 does not fit in ADDR_W.
REQ-019 The FSM SHALL have exactly four states: IDLE, MAC, FLUSH, DONE.
REQ-020 start_ready SHALL be 1 only in IDLE.
REQ-021 IDLE -> MAC SHALL occur on start_valid&&start_ready, with all counters (ts, oy, ox, fy, fx) set to 0.
REQ-022 Loop order SHALL be, outermost to innermost: ts, oy, ox, fy, fx.
REQ-023 In MAC, cmd_valid SHALL be 1, cmd_flush 0, and cmd_acc_clear 1 only when fy==0&&fx==0.
REQ-024 A command SHALL transfer only on a cycle with cmd_valid&&cmd_ready.
REQ-025 All cmd_* outputs SHALL hold stable while cmd_valid&&!cmd_ready.
REQ-026 In MAC, each transfer SHALL advance fx, and fy on fx wrap; after the transfer with fy=fx=FILTER_LEN-1 the FSM SHALL enter FLUSH.
REQ-027 FLUSH SHALL issue one command with cmd_flush=1, cmd_acc_clear=0, and both addresses held at their last MAC values.
REQ-028 On the FLUSH transfer, ox SHALL advance, then oy on ox wrap, then ts on oy wrap, and the FSM SHALL return to MAC.
REQ-029 On the FLUSH transfer of the last pixel of the last time step, the FSM SHALL enter DONE.
REQ-030 DONE SHALL drive done_valid=1 and SHALL return to IDLE on done_ready.
REQ-031 Every command, flush included, SHALL take at least one cycle; back-to-back transfers SHALL be possible when cmd_ready is held at 1.
REQ-032 Total commands per start SHALL equal TIMESTEPS*OUT_LEN^2*(FILTER_LEN^2+1).
REQ-033 An abort=1 in MAC, FLUSH or DONE SHALL take effect at the next edge: FSM to IDLE, cmd_valid=0, no done, counters cleared.
REQ-034 An abort in IDLE SHALL have no effect.
REQ-035 When start_valid and abort are both 1 in IDLE, the start SHALL be accepted.
REQ-036 Address arithmetic SHALL be unsigned; each counter SHALL wrap to 0 exactly at its bound, with no overflow beyond it.

Reset
REQ-037 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear all counters.
REQ-038 Reset values SHALL be: start_ready=1, cmd_valid=0, done_valid=0, every cmd_* field 0.
REQ-039 A reset asserted mid-run SHALL discard the run, produce no done, and behave identically to power-on reset.

Verification
REQ-040 Defaults, cmd_ready=1, one start -> 90 commands; cmd1 (filter 0, ifmap 0, clear=1); cmd2 (1, 1, clear=0); cmd4 (3, 5); cmd10 flush=1; cmd11 (0, 1, clear=1); last MAC (8, 24); done_valid one cycle after cmd90.
REQ-041 Defaults, cmd_ready toggled randomly -> fields stable while stalled; same 90-command sequence as REQ-040 in the same order.
REQ-042 IFMAP_LEN=6, FILTER_LEN=2, STRIDE=2, TIMESTEPS=2 -> OUT_LEN=3, 90 commands; pixel (1,1) first ifmap addr 14; cmd_ts=1 from cmd46.
REQ-043 start_valid held during a run -> start_ready=0 and the start is not accepted until after the done handshake.
REQ-044 abort at cmd 37 -> cmd_valid=0 the next cycle, done_valid stays 0, start_ready=1; a new start restarts at filter 0, ifmap 0.
REQ-045 rst_n=0 for one cycle at cmd 50 with done_ready=0 held in DONE -> all outputs at reset values; a new start yields the full REQ-040 sequence.
